sensor_alarm_ctrl: RTL and testbench
====================================

SENSOR_ALARM_CTRL -- requirements
Module: sensor_alarm_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed before the debounced switch vector updates (range 2..65535).
REQ-002 Parameter BLINK_HALF, default 8: cycles per half-period of the red alarm blink (range 1..65535).
REQ-003 Port clk, input, 1: single system clock, all state on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port sw, input, 4: raw, asynchronous sensor switches: sw[0]=CT, sw[1]=CL, sw[2]=OT, sw[3]=OL.
REQ-006 Port ack, input, 1: alarm acknowledge, level, synchronous to clk.
REQ-007 Port led, output, 2: led[0]=blue (normal), led[1]=red (alarm).
REQ-008 Port alarm_active, output, 1: high while FSM is in ALARM.
REQ-009 Port alarm_cnt, output, 8: saturating count of ALARM entries since reset.

Function
REQ-010 sw SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 A debounce counter SHALL clear whenever the synchronized vector differs from its value in the previous cycle; once the counter reaches DEBOUNCE_CYCLES, the debounced vector db SHALL load the synchronized vector.
REQ-012 Decode from db: blue_c = db in {4'b0010, 4'b1000, 4'b0100, 4'b1001}; red_c = (CT&CL) | (OT&OL) | (CT&OT).
REQ-013 FSM states: IDLE, NORMAL, ALARM.
REQ-014 IDLE: red_c -> ALARM; else blue_c -> NORMAL; else stay.
REQ-015 NORMAL: red_c -> ALARM; else !blue_c -> IDLE; else stay.
REQ-016 ALARM: exit only when ack=1 and red_c=0 in the same cycle, then -> IDLE; ack while red_c=1 is ignored; ALARM remains latched when red_c drops without ack.
REQ-017 red_c has priority over blue_c in every state.
REQ-018 Outputs registered: led[0]=1 only in NORMAL; led[1]=0 outside ALARM.
REQ-019 In ALARM, led[1]=1 for the first BLINK_HALF cycles after entry, then toggles every BLINK_HALF cycles; the blink counter clears on each ALARM entry.
REQ-020 alarm_active=1 exactly in the cycles the FSM is in ALARM.
REQ-021 alarm_cnt SHALL increment by 1 on every transition into ALARM and saturate at 255.
REQ-022 Latency: a sw change held stable reaches led at most 2 + DEBOUNCE_CYCLES + 2 cycles later; each state transition is visible on outputs the cycle after it occurs.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES SHALL NOT change db, the FSM state or the outputs.

Reset
REQ-024 rst_n low SHALL asynchronously clear synchronizer flops, db (4'b0000), debounce and blink counters, alarm_cnt (0), FSM state (IDLE), led (2'b00) and alarm_active (0).
REQ-025 Reset asserted mid-ALARM SHALL drop the alarm immediately; after release the block re-evaluates from IDLE, and a red_c condition still present re-enters ALARM and increments alarm_cnt to 1.

Structure
REQ-026 Shared package sensor_alarm_pkg SHALL hold the state enum, the switch index constants (CT/CL/OT/OL) and the four blue_c code constants.
REQ-027 Synchronizer plus debounce SHALL be a sub-module sw_debounce (parameter DEBOUNCE_CYCLES, WIDTH=4); the FSM, decode, blink and counter logic stay in sensor_alarm_ctrl.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF=3)
REQ-028 Reset, sw=4'b0010 held -> led=2'b01 within 8 cycles, alarm_cnt=0.
REQ-029 sw=4'b0011 held -> led[1] pattern 1,1,1,0,0,0,1 from ALARM entry, alarm_active=1, alarm_cnt=1; sw=4'b0000 with ack=0 -> alarm persists.
REQ-030 In ALARM with sw=4'b1100 and ack=1 -> stays in ALARM; sw=4'b0000, ack=1 after db settles -> IDLE, led=2'b00.
REQ-031 sw=4'b0010 with a 3-cycle pulse to 4'b0011 -> led stays 2'b01, alarm_cnt unchanged.
REQ-032 Enter ALARM 300 times -> alarm_cnt=255.
REQ-033 rst_n low mid-ALARM with sw=4'b0101 held -> led=2'b00 immediately; after release ALARM re-entered, alarm_cnt=1.

Source files
------------

// File: rtl/sensor_alarm_pkg.sv
// rtl/sensor_alarm_pkg.sv - shared types and constants for the sensor alarm controller
package sensor_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORMAL = 2'd1,
    ALARM  = 2'd2
  } state_t;

  // Bit positions of each sensor inside the switch vector
  localparam int CT = 0;
  localparam int CL = 1;
  localparam int OT = 2;
  localparam int OL = 3;

  // Exact switch codes that mean "normal operation"
  localparam logic [3:0] BLUE_CODE0 = 4'b0010;
  localparam logic [3:0] BLUE_CODE1 = 4'b1000;
  localparam logic [3:0] BLUE_CODE2 = 4'b0100;
  localparam logic [3:0] BLUE_CODE3 = 4'b1001;

  function automatic logic is_blue(input logic [3:0] v);
    return (v == BLUE_CODE0) || (v == BLUE_CODE1) ||
           (v == BLUE_CODE2) || (v == BLUE_CODE3);
  endfunction

  function automatic logic is_red(input logic [3:0] v);
    return (v[CT] & v[CL]) | (v[OT] & v[OL]) | (v[CT] & v[OT]);
  endfunction

endpackage

// File: rtl/sensor_alarm_ctrl_if.sv
// rtl/sensor_alarm_ctrl_if.sv - switch/ack inputs and indicator outputs of the alarm controller
interface sensor_alarm_ctrl_if;
  logic [3:0] sw;
  logic       ack;
  logic [1:0] led;
  logic       alarm_active;
  logic [7:0] alarm_cnt;

  modport master (
    output sw,
    output ack,
    input  led,
    input  alarm_active,
    input  alarm_cnt
  );

  modport slave (
    input  sw,
    input  ack,
    output led,
    output alarm_active,
    output alarm_cnt
  );
endinterface

// File: rtl/sensor_alarm_ctrl_sw_debounce.sv
// rtl/sensor_alarm_ctrl_sw_debounce.sv - two-flop synchronizer plus stability debounce for the switches
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIDTH           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] db
);

  // The counter parks one below DEBOUNCE_CYCLES; load happens on the cycle it would reach it
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [15:0]      cnt;

  // Bring the raw switches into the clk domain and keep last cycle's value for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Count stable cycles; any change restarts the count, a full count commits the vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= '0;
    end else begin
      if (sync2 != prev) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 16'd1;
      end
      if ((sync2 == prev) && (cnt == CNT_LAST)) begin
        db <= sync2;
      end
    end
  end

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// rtl/sensor_alarm_ctrl.sv - debounced sensor decode, alarm FSM, red blink and alarm entry counter
module sensor_alarm_ctrl
  import sensor_alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_HALF      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sensor_alarm_ctrl_if.slave   bus
);

  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

  logic [3:0]  db;
  logic        blue_c;
  logic        red_c;
  state_t      state;
  logic [15:0] blink_cnt;
  logic [1:0]  led_q;
  logic        active_q;
  logic [7:0]  cnt_q;

  sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WIDTH           (4)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.sw),
    .db    (db)
  );

  assign blue_c = is_blue(db);
  assign red_c  = is_red(db);

  assign bus.led          = led_q;
  assign bus.alarm_active = active_q;
  assign bus.alarm_cnt    = cnt_q;

  // State machine with outputs registered alongside the state; red always wins over blue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      led_q     <= 2'b00;
      active_q  <= 1'b0;
      blink_cnt <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE, NORMAL: begin
          if (red_c) begin
            state     <= ALARM;
            led_q     <= 2'b10;
            active_q  <= 1'b1;
            blink_cnt <= '0;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
          end else if (blue_c) begin
            state <= NORMAL;
            led_q <= 2'b01;
          end else begin
            state <= IDLE;
            led_q <= 2'b00;
          end
        end
        ALARM: begin
          // Alarm is latched: only an acknowledge with the red condition gone releases it
          if (bus.ack && !red_c) begin
            state    <= IDLE;
            led_q    <= 2'b00;
            active_q <= 1'b0;
          end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            led_q[1]  <= ~led_q[1];
          end else begin
            blink_cnt <= blink_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          led_q    <= 2'b00;
          active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb/tb_sensor_alarm_ctrl.sv - directed self-checking bench for sensor_alarm_ctrl
module tb_sensor_alarm_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  sensor_alarm_ctrl_if bus();

  sensor_alarm_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .BLINK_HALF      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_active(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.alarm_active === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.sw  = 4'b0000;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.led !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_led got=%b want=00", bus.led);
    end
    vectors++;
    if (bus.alarm_active !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_active got=%b want=0", bus.alarm_active);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_cnt got=%0d want=0", bus.alarm_cnt);
    end
  endtask

  task automatic test_normal();
    bit seen;
    rst_n  = 1'b1;
    bus.sw = 4'b0010;
    seen   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led === 2'b01) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL normal_led got=%b want=01 within 8 cycles", bus.led);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL normal_cnt got=%0d want=0", bus.alarm_cnt);
    end
  endtask

  task automatic test_alarm();
    bit         ok;
    logic [6:0] pat;
    pat    = 7'b1000111;
    bus.sw = 4'b0011;
    wait_active(1'b1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL alarm_entry got=%b want=1 within 20 cycles", bus.alarm_active);
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (bus.led !== {pat[i], 1'b0}) begin
        miscompares++;
        $display("FAIL blink_%0d got=%b want=%b", i, bus.led, {pat[i], 1'b0});
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL alarm_cnt got=%0d want=1", bus.alarm_cnt);
    end
    bus.sw  = 4'b0000;
    bus.ack = 1'b0;
    repeat (15) @(negedge clk);
    vectors++;
    if (bus.alarm_active !== 1'b1) begin
      miscompares++;
      $display("FAIL alarm_latched got=%b want=1", bus.alarm_active);
    end
  endtask

  task automatic test_ack();
    bus.sw = 4'b1100;
    repeat (12) @(negedge clk);
    bus.ack = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.alarm_active !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_while_red got=%b want=1", bus.alarm_active);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL ack_while_red_cnt got=%0d want=1", bus.alarm_cnt);
    end
    bus.ack = 1'b0;
    bus.sw  = 4'b0000;
    repeat (12) @(negedge clk);
    vectors++;
    if (bus.alarm_active !== 1'b1) begin
      miscompares++;
      $display("FAIL settled_no_ack got=%b want=1", bus.alarm_active);
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    vectors++;
    if (bus.alarm_active !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_exit_active got=%b want=0", bus.alarm_active);
    end
    vectors++;
    if (bus.led !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_exit_led got=%b want=00", bus.led);
    end
  endtask

  task automatic test_glitch();
    bit stable;
    bus.sw = 4'b0010;
    repeat (12) @(negedge clk);
    vectors++;
    if (bus.led !== 2'b01) begin
      miscompares++;
      $display("FAIL glitch_pre_led got=%b want=01", bus.led);
    end
    bus.sw = 4'b0011;
    repeat (3) @(negedge clk);
    bus.sw = 4'b0010;
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.led !== 2'b01 || bus.alarm_active !== 1'b0) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL glitch_led got=%b want=01 throughout", bus.led);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL glitch_cnt got=%0d want=1", bus.alarm_cnt);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int exp_cnt;
    exp_cnt = 1;
    bus.ack = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      bus.sw = 4'b0011;
      wait_active(1'b1, 20, ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL sat_entry_%0d got=%b want=1", i, bus.alarm_active);
        break;
      end
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      if (i == 10 || i == 254 || i == 255) begin
        vectors++;
        if (bus.alarm_cnt !== 8'(exp_cnt)) begin
          miscompares++;
          $display("FAIL sat_cnt_%0d got=%0d want=%0d", i, bus.alarm_cnt, exp_cnt);
        end
      end
      bus.sw = 4'b0000;
      wait_active(1'b0, 20, ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL sat_exit_%0d got=%b want=0", i, bus.alarm_active);
        break;
      end
    end
    bus.ack = 1'b0;
    vectors++;
    if (bus.alarm_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_final got=%0d want=255", bus.alarm_cnt);
    end
  endtask

  task automatic test_reset_mid_alarm();
    bit ok;
    bus.sw  = 4'b0101;
    bus.ack = 1'b0;
    wait_active(1'b1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL mid_entry got=%b want=1", bus.alarm_active);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.led !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset_led got=%b want=00", bus.led);
    end
    vectors++;
    if (bus.alarm_active !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_active got=%b want=0", bus.alarm_active);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset_cnt got=%0d want=0", bus.alarm_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_active(1'b1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reentry got=%b want=1", bus.alarm_active);
    end
    vectors++;
    if (bus.alarm_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL reentry_cnt got=%0d want=1", bus.alarm_cnt);
    end
    vectors++;
    if (bus.led !== 2'b10) begin
      miscompares++;
      $display("FAIL reentry_led got=%b want=10", bus.led);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_normal();
    test_alarm();
    test_ack();
    test_glitch();
    test_saturate();
    test_reset_mid_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
